// File: rtl/irq_timer_bank.sv
// Bank of N_CH periodic interrupt timers with pending, overrun, mask and priority request.
module irq_timer_bank #(
    parameter int unsigned    N_CH      = 4,
    parameter int unsigned    CNT_W     = 16,
    parameter int unsigned    DIV_RESET = 6249,
    parameter logic [N_CH-1:0] EN_RESET = N_CH'(1),
    localparam int unsigned   ID_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [ID_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic             cfg_en,
    input  logic [N_CH-1:0]  ack,
    input  logic [N_CH-1:0]  mask,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pending,
    output logic [N_CH-1:0]  overrun,
    output logic             ei_req,
    output logic [ID_W-1:0]  irq_id
);

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] div_q [N_CH];
    logic [CNT_W-1:0] div_d [N_CH];
    logic [N_CH-1:0]  en_q, en_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  overrun_q, overrun_d;
    logic [N_CH-1:0]  wr_c;
    logic [N_CH-1:0]  hit_c;

    // Decode the config write; selects beyond the last channel match nothing.
    always_comb begin
        wr_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_c[i] = cfg_we && (cfg_ch == ID_W'(i));
        end
    end

    // Period boundary per channel; a config write on the same edge suppresses it.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit_c[i] = en_q[i] && (cnt_q[i] == div_q[i]) && !wr_c[i];
        end
    end

    // Next-state for counters, configuration, tick, pending and overrun.
    always_comb begin
        cnt_d     = cnt_q;
        div_d     = div_q;
        en_d      = en_q;
        tick_d    = '0;
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_c[i]) begin
                div_d[i] = cfg_div;
                en_d[i]  = cfg_en;
                cnt_d[i] = '0;
            end else if (!en_q[i] || hit_c[i]) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            tick_d[i] = hit_c[i];

            // Set beats ack so no event is lost; ack always consumes prior overrun.
            if (hit_c[i]) begin
                pending_d[i] = 1'b1;
                if (ack[i]) begin
                    overrun_d[i] = 1'b0;
                end else if (pending_q[i]) begin
                    overrun_d[i] = 1'b1;
                end
            end else if (ack[i]) begin
                pending_d[i] = 1'b0;
                overrun_d[i] = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= CNT_W'(DIV_RESET);
            end
            en_q      <= EN_RESET;
            tick_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            en_q      <= en_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    // Request and lowest-index priority encode from registered pending and live mask.
    always_comb begin
        ei_req = |(pending_q & ~mask);
        irq_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending_q[i] && !mask[i]) begin
                irq_id = ID_W'(i);
            end
        end
    end

    assign tick    = tick_q;
    assign pending = pending_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_irq_timer_bank.sv
// Directed bench for irq_timer_bank: vector table plus long-period hand sequences.
module tb_irq_timer_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic [3:0]  ack;
    logic [3:0]  mask;
    logic [3:0]  tick;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic        ei_req;
    logic [1:0]  irq_id;

    int n_checks = 0;
    int n_fail   = 0;

    irq_timer_bank #(
        .N_CH(4), .CNT_W(16), .DIV_RESET(6249), .EN_RESET(4'b0001)
    ) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_en(cfg_en), .ack(ack), .mask(mask), .tick(tick), .pending(pending),
        .overrun(overrun), .ei_req(ei_req), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  ch;
        logic [15:0] div;
        logic        en;
        logic [3:0]  ack;
        logic [3:0]  mask;
        logic [3:0]  e_tick;
        logic [3:0]  e_pend;
        logic [3:0]  e_ovr;
        logic        e_ei;
        logic [1:0]  e_id;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Apply inputs, take one clock edge, then sample 1 ns later.
    task automatic step(input logic we, input logic [1:0] ch, input logic [15:0] dv,
                        input logic en, input logic [3:0] ak, input logic [3:0] mk);
        cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_en = en; ack = ak; mask = mk;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b0000);
    endtask

    task automatic check_all(input string tag, input logic [3:0] t, input logic [3:0] p,
                             input logic [3:0] o, input logic e, input logic [1:0] id);
        check({tag, " tick"},    32'(tick),    32'(t));
        check({tag, " pending"}, 32'(pending), 32'(p));
        check({tag, " overrun"}, 32'(overrun), 32'(o));
        check({tag, " ei_req"},  32'(ei_req),  32'(e));
        check({tag, " irq_id"},  32'(irq_id),  32'(id));
    endtask

    initial begin
        int first_t;
        int second_t;
        int n_t0;
        int n_other;
        int found;

        // we ch div en ack mask | tick pend ovr ei id
        vecs.push_back('{1'b1, 2'd0, 16'd6249, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 2'd2, 16'd3,    1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2});
        vecs.push_back('{1'b1, 2'd2, 16'd3,    1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 2'd1, 16'd0,    1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 1'b1, 2'd1});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1});
        vecs.push_back('{1'b1, 2'd3, 16'd0,    1'b1, 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 1'b1, 2'd1});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b0010, 4'b1010, 4'b1010, 4'b0010, 1'b1, 2'd3});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 1'b0, 2'd0});
        vecs.push_back('{1'b1, 2'd1, 16'd0,    1'b0, 4'b0000, 4'b0010, 4'b1000, 4'b1010, 4'b1010, 1'b1, 2'd3});
        vecs.push_back('{1'b1, 2'd3, 16'd0,    1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b1010, 1'b1, 2'd1});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 1'b1, 2'd3});
        vecs.push_back('{1'b0, 2'd0, 16'd0,    1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0});

        // Reset state.
        rst = 1'b1;
        repeat (3) idle();
        check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Default config: only ch0 runs, period 6250.
        rst = 1'b0;
        first_t = -1; second_t = -1; n_t0 = 0; n_other = 0;
        for (int k = 1; k <= 12500; k++) begin
            idle();
            if (tick[0]) begin
                n_t0++;
                if (first_t < 0) first_t = k;
                else if (second_t < 0) second_t = k;
            end
            if (|tick[3:1]) n_other++;
            if (k == 6250) begin
                check("default ei_req at first tick", 32'(ei_req), 32'd1);
                check("default irq_id at first tick", 32'(irq_id), 32'd0);
            end
        end
        check("default first tick cycle", 32'(first_t), 32'd6250);
        check("default second tick cycle", 32'(second_t), 32'd12500);
        check("default ch0 tick count", 32'(n_t0), 32'd2);
        check("default other ticks", 32'(n_other), 32'd0);
        check("default overrun after 2nd tick", 32'(overrun), 32'b0001);

        // Vector table.
        foreach (vecs[v]) begin
            step(vecs[v].we, vecs[v].ch, vecs[v].div, vecs[v].en, vecs[v].ack, vecs[v].mask);
            check_all($sformatf("vec%0d", v), vecs[v].e_tick, vecs[v].e_pend,
                      vecs[v].e_ovr, vecs[v].e_ei, vecs[v].e_id);
        end

        // Mid-count reset: bring ch0 to cnt=5000 with pending set, then reset.
        step(1'b1, 2'd0, 16'd6249, 1'b1, 4'b0000, 4'b0000);
        found = -1;
        for (int k = 1; k <= 7000 && found < 0; k++) begin
            idle();
            if (tick[0]) found = k;
        end
        check("reenable first tick latency", 32'(found), 32'd6250);
        repeat (5000) idle();
        check("pre-reset pending", 32'(pending), 32'b0001);
        rst = 1'b1;
        idle();
        check_all("midreset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        rst = 1'b0;
        found = -1;
        for (int k = 1; k <= 7000 && found < 0; k++) begin
            idle();
            if (tick[0]) found = k;
        end
        check("post-reset tick latency", 32'(found), 32'd6250);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
